udma_adc_scan_sched: RTL and testbench
======================================

Name: udma_adc_scan_sched

Overview:
- Periodic scan scheduler for the uDMA ADC rx channel.
- Paces conversions with a programmable sample tick and picks the next channel round-robin from the enabled set, or one fixed channel in single-channel mode.
- Runs the request/ack/data handshake with the ADC front-end.
- Delivers each sample, tagged with its channel ID, over a valid/ready stream to the per-channel uDMA rx path.

Parameters:
- ADC_NUM_CHS, 8: number of ADC channels.
- CH_ID_WIDTH, 3: channel ID width; must satisfy 2**CH_ID_WIDTH >= ADC_NUM_CHS.
- DATA_WIDTH, 16: ADC sample width.
- DIV_WIDTH, 16: width of the sample period counter.
- TIMEOUT_CYCLES, 255: abort limit, used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- cfg_run_i  in  1  scheduler enable (level).
- cfg_ch_en_i  in  ADC_NUM_CHS  per-channel enable mask.
- cfg_single_ch_mode_i  in  1  single-channel mode.
- cfg_single_ch_sel_i  in  CH_ID_WIDTH  channel used in single-channel mode.
- cfg_period_i  in  DIV_WIDTH  tick period minus 1, in clk_i cycles.
- adc_req_o  out  1  conversion request.
- adc_ch_o  out  CH_ID_WIDTH  channel to convert.
- adc_ack_i  in  1  request accepted.
- adc_valid_i  in  1  conversion result valid (1-cycle pulse).
- adc_data_i  in  DATA_WIDTH  conversion result.
- smp_valid_o  out  1  sample valid.
- smp_ready_i  in  1  sample accepted.
- smp_data_o  out  DATA_WIDTH  sample data.
- smp_ch_o  out  CH_ID_WIDTH  sample channel ID.
- busy_o  out  1  FSM not in IDLE.
- overrun_o  out  1  1-cycle pulse: tick dropped.
- err_timeout_o  out  1  1-cycle pulse: conversion aborted.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE, tick counter 0.
  - last_ch = ADC_NUM_CHS-1, so the first grant is the lowest enabled channel.
- Tick counter:
  - cfg_run_i=0: counter held at 0, no tick.
  - cfg_run_i=1: counter increments each cycle.
  - Tick asserted in the cycle where counter==cfg_period_i; counter returns to 0 on the next cycle.
  - cfg_period_i=0 gives a tick every cycle.
- Candidate set:
  - Single-channel mode: only cfg_single_ch_sel_i, and only if its cfg_ch_en_i bit is set. A select value >= ADC_NUM_CHS gives an empty set.
  - Otherwise: cfg_ch_en_i.
- Round-robin:
  - Grant = lowest-indexed candidate strictly above last_ch, wrapping to index 0.
  - A single candidate is re-granted every time.
- FSM:
  - IDLE: on tick with a non-empty candidate set, register the grant into adc_ch_o/smp_ch_o, set adc_req_o=1, go to REQ. Tick with an empty set is silently ignored. Latency: tick in cycle t gives adc_req_o=1 in cycle t+1.
  - REQ: adc_req_o and adc_ch_o held stable until adc_ack_i. On the ack cycle, adc_req_o drops next cycle and the FSM goes to CONV. An ack in the first REQ cycle is legal.
  - CONV: wait for adc_valid_i, then capture adc_data_i into smp_data_o, set smp_valid_o=1, go to PUSH. adc_valid_i in any other state is ignored.
  - PUSH: smp_valid_o, smp_data_o and smp_ch_o held stable until smp_ready_i. On the handshake: smp_valid_o=0 next cycle, last_ch = granted channel, go to IDLE.
- Overrun:
  - A tick while state != IDLE is dropped (not queued) and pulses overrun_o for 1 cycle.
  - The tick counter keeps running.
- Mid-operation changes:
  - cfg_run_i deasserted mid-operation: the in-flight conversion completes and its sample is delivered; no further ticks.
  - cfg_ch_en_i, cfg_single_ch_mode_i or cfg_single_ch_sel_i changes do not affect the in-flight channel; they apply at the next grant.
- busy_o is combinational: state != IDLE.
- Asynchronous reset mid-operation: immediate return to reset values; the in-flight sample is lost.

Optional Feature:
- Macro: ADC_SCHED_TIMEOUT_EN.
- Defined:
  - A cycle counter runs across REQ+CONV and is cleared on entering REQ.
  - If it reaches TIMEOUT_CYCLES before adc_valid_i: adc_req_o=0, err_timeout_o pulses 1 cycle, last_ch = granted channel (the channel is skipped), FSM returns to IDLE.
  - A late adc_valid_i is then ignored.
- Not defined:
  - REQ/CONV wait indefinitely.
  - err_timeout_o is tied to 0; the port is always present.

Test Plan:
- Round-robin scan: ch_en=8'b1010_0101, period=9, ADC acks next cycle, valid 3 cycles later, ready=1 -> smp_ch_o sequence 0,2,5,7,0,...; one sample every 10 cycles; adc_req_o rises 1 cycle after each tick.
- Single-channel mode: sel=3. With ch_en[3]=1 -> only channel 3 sampled. With ch_en[3]=0 -> no adc_req_o; busy_o stays 0.
- Overrun and backpressure: period=0, smp_ready_i=0 for 20 cycles -> overrun_o pulses every cycle while busy; smp_data_o/smp_ch_o stable; exactly one sample delivered when ready rises.
- Stop mid-conversion: cfg_run_i=0 in CONV -> sample still delivered with correct channel; FSM back in IDLE; no further adc_req_o.
- Reset mid-operation: rstn_i low in PUSH -> smp_valid_o=0 immediately; first grant after reset is the lowest enabled channel.
- Timeout (ADC_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16): ADC never asserts adc_valid_i on ch 2 -> err_timeout_o pulses 16 cycles after REQ entry; next grant is the channel after 2.

Source files
------------

// File: rtl/udma_adc_scan_sched.sv
// Periodic ADC scan scheduler: paces conversions, picks channels round-robin and streams tagged samples.
// Optional conversion timeout is enabled by defining ADC_SCHED_TIMEOUT_EN.
module udma_adc_scan_sched #(
  parameter int ADC_NUM_CHS    = 8,
  parameter int CH_ID_WIDTH    = 3,
  parameter int DATA_WIDTH     = 16,
  parameter int DIV_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   cfg_run_i,
  input  logic [ADC_NUM_CHS-1:0] cfg_ch_en_i,
  input  logic                   cfg_single_ch_mode_i,
  input  logic [CH_ID_WIDTH-1:0] cfg_single_ch_sel_i,
  input  logic [DIV_WIDTH-1:0]   cfg_period_i,
  output logic                   adc_req_o,
  output logic [CH_ID_WIDTH-1:0] adc_ch_o,
  input  logic                   adc_ack_i,
  input  logic                   adc_valid_i,
  input  logic [DATA_WIDTH-1:0]  adc_data_i,
  output logic                   smp_valid_o,
  input  logic                   smp_ready_i,
  output logic [DATA_WIDTH-1:0]  smp_data_o,
  output logic [CH_ID_WIDTH-1:0] smp_ch_o,
  output logic                   busy_o,
  output logic                   overrun_o,
  output logic                   err_timeout_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CONV,
    PUSH
  } state_e;

  if ((2 ** CH_ID_WIDTH) < ADC_NUM_CHS || TIMEOUT_CYCLES < 1) begin : gBadParams
    $error("udma_adc_scan_sched: invalid parameter combination");
  end

  state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   tickCnt_q, tickCnt_d;
  logic [CH_ID_WIDTH-1:0] lastCh_q, lastCh_d;
  logic [CH_ID_WIDTH-1:0] ch_q, ch_d;
  logic                   adcReq_q, adcReq_d;
  logic                   smpValid_q, smpValid_d;
  logic [DATA_WIDTH-1:0]  smpData_q, smpData_d;
  logic                   tick;
  logic                   grantValid;
  logic [CH_ID_WIDTH-1:0] grant;
  logic [ADC_NUM_CHS-1:0] candidates;

`ifdef ADC_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] toCnt_q, toCnt_d;
  logic            errTimeout_q, errTimeout_d;
`endif

  assign tick = cfg_run_i && (tickCnt_q == cfg_period_i);

  always_comb begin
    tickCnt_d = '0;
    if (cfg_run_i && !tick) begin
      tickCnt_d = tickCnt_q + DIV_WIDTH'(1);
    end
  end

  // Out-of-range select values match no bit, so they yield an empty set.
  always_comb begin
    candidates = cfg_ch_en_i;
    if (cfg_single_ch_mode_i) begin
      for (int i = 0; i < ADC_NUM_CHS; i++) begin
        candidates[i] = cfg_ch_en_i[i] && (cfg_single_ch_sel_i == CH_ID_WIDTH'(i));
      end
    end
  end

  // Descending scans leave the lowest match; the second pass prefers channels above last_ch.
  always_comb begin
    grant      = '0;
    grantValid = |candidates;
    for (int i = ADC_NUM_CHS - 1; i >= 0; i--) begin
      if (candidates[i]) begin
        grant = CH_ID_WIDTH'(i);
      end
    end
    for (int i = ADC_NUM_CHS - 1; i >= 0; i--) begin
      if (candidates[i] && (CH_ID_WIDTH'(i) > lastCh_q)) begin
        grant = CH_ID_WIDTH'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lastCh_d   = lastCh_q;
    ch_d       = ch_q;
    adcReq_d   = adcReq_q;
    smpValid_d = smpValid_q;
    smpData_d  = smpData_q;
`ifdef ADC_SCHED_TIMEOUT_EN
    toCnt_d      = toCnt_q;
    errTimeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (tick && grantValid) begin
          ch_d     = grant;
          adcReq_d = 1'b1;
          state_d  = REQ;
`ifdef ADC_SCHED_TIMEOUT_EN
          toCnt_d  = '0;
`endif
        end
      end
      REQ: begin
        if (adc_ack_i) begin
          adcReq_d = 1'b0;
          state_d  = CONV;
        end
      end
      CONV: begin
        if (adc_valid_i) begin
          smpData_d  = adc_data_i;
          smpValid_d = 1'b1;
          state_d    = PUSH;
        end
      end
      PUSH: begin
        if (smp_ready_i) begin
          smpValid_d = 1'b0;
          lastCh_d   = ch_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef ADC_SCHED_TIMEOUT_EN
    // A result arriving in the final cycle still wins over the abort.
    if ((state_q == REQ) || ((state_q == CONV) && !adc_valid_i)) begin
      if (toCnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        adcReq_d     = 1'b0;
        errTimeout_d = 1'b1;
        lastCh_d     = ch_q;
        state_d      = IDLE;
      end else begin
        toCnt_d = toCnt_q + TO_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      tickCnt_q  <= '0;
      lastCh_q   <= CH_ID_WIDTH'(ADC_NUM_CHS - 1);
      ch_q       <= '0;
      adcReq_q   <= 1'b0;
      smpValid_q <= 1'b0;
      smpData_q  <= '0;
    end else begin
      state_q    <= state_d;
      tickCnt_q  <= tickCnt_d;
      lastCh_q   <= lastCh_d;
      ch_q       <= ch_d;
      adcReq_q   <= adcReq_d;
      smpValid_q <= smpValid_d;
      smpData_q  <= smpData_d;
    end
  end

`ifdef ADC_SCHED_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      toCnt_q      <= '0;
      errTimeout_q <= 1'b0;
    end else begin
      toCnt_q      <= toCnt_d;
      errTimeout_q <= errTimeout_d;
    end
  end
  assign err_timeout_o = errTimeout_q;
`else
  assign err_timeout_o = 1'b0;
`endif

  assign adc_req_o   = adcReq_q;
  assign adc_ch_o    = ch_q;
  assign smp_valid_o = smpValid_q;
  assign smp_data_o  = smpData_q;
  assign smp_ch_o    = ch_q;
  assign busy_o      = (state_q != IDLE);
  assign overrun_o   = tick && (state_q != IDLE);

endmodule

// File: tb/tb_udma_adc_scan_sched.sv
// Testbench for udma_adc_scan_sched: table-driven scan vectors plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_udma_adc_scan_sched;

  localparam int NCH  = 8;
  localparam int CHW  = 3;
  localparam int DW   = 16;
  localparam int DIVW = 16;

  logic            clk_i = 1'b0;
  logic            rstn_i;
  logic            cfg_run_i;
  logic [NCH-1:0]  cfg_ch_en_i;
  logic            cfg_single_ch_mode_i;
  logic [CHW-1:0]  cfg_single_ch_sel_i;
  logic [DIVW-1:0] cfg_period_i;
  logic            adc_req_o;
  logic [CHW-1:0]  adc_ch_o;
  logic            adc_ack_i;
  logic            adc_valid_i;
  logic [DW-1:0]   adc_data_i;
  logic            smp_valid_o;
  logic            smp_ready_i;
  logic [DW-1:0]   smp_data_o;
  logic [CHW-1:0]  smp_ch_o;
  logic            busy_o;
  logic            overrun_o;
  logic            err_timeout_o;

  udma_adc_scan_sched #(
    .ADC_NUM_CHS   (NCH),
    .CH_ID_WIDTH   (CHW),
    .DATA_WIDTH    (DW),
    .DIV_WIDTH     (DIVW),
`ifdef ADC_SCHED_TIMEOUT_EN
    .TIMEOUT_CYCLES(16)
`else
    .TIMEOUT_CYCLES(255)
`endif
  ) dut (
    .clk_i               (clk_i),
    .rstn_i              (rstn_i),
    .cfg_run_i           (cfg_run_i),
    .cfg_ch_en_i         (cfg_ch_en_i),
    .cfg_single_ch_mode_i(cfg_single_ch_mode_i),
    .cfg_single_ch_sel_i (cfg_single_ch_sel_i),
    .cfg_period_i        (cfg_period_i),
    .adc_req_o           (adc_req_o),
    .adc_ch_o            (adc_ch_o),
    .adc_ack_i           (adc_ack_i),
    .adc_valid_i         (adc_valid_i),
    .adc_data_i          (adc_data_i),
    .smp_valid_o         (smp_valid_o),
    .smp_ready_i         (smp_ready_i),
    .smp_data_o          (smp_data_o),
    .smp_ch_o            (smp_ch_o),
    .busy_o              (busy_o),
    .overrun_o           (overrun_o),
    .err_timeout_o       (err_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [NCH-1:0]     chEn;
    logic               single;
    logic [CHW-1:0]     sel;
    logic [DIVW-1:0]    period;
    logic [1:0]         ackDly;
    logic [3:0]         nGrants;
    logic [5:0][CHW-1:0] expCh;
  } vec_t;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [DW-1:0]  data;
  } smp_t;

  typedef enum int {R_IDLE, R_ACK, R_VAL} resp_e;

  int             assertCount = 0;
  int             failCount   = 0;
  int             cycleCnt    = 0;
  logic [CHW-1:0] chanQ [$];
  smp_t           sbQ [$];
  vec_t           vecs [6];

  resp_e          rs = R_IDLE;
  int             ackDelay = 1;
  int             validDelay = 3;
  int             ac, vc;
  int             muteCh = -1;
  logic [CHW-1:0] curCh;
  bit             checkSpacing = 0;
  int             spacing = 10;
  int             prevReqCycle = 0;
  int             lastReqCycle = 0;

  bit             holdValid = 0;
  logic [DW-1:0]  holdData;
  logic [CHW-1:0] holdCh;
  smp_t           expSmp;
  int             delivered = 0;
  bit             noOverrunExpected = 0;
  int             errPulses = 0;

  always @(posedge clk_i) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  // ADC front-end model: acks after ackDelay cycles, returns a random result validDelay cycles later.
  initial begin
    adc_ack_i   = 1'b0;
    adc_valid_i = 1'b0;
    adc_data_i  = '0;
    forever begin
      @(negedge clk_i);
      adc_ack_i   = 1'b0;
      adc_valid_i = 1'b0;
      if (!rstn_i) begin
        rs = R_IDLE;
      end else begin
        if (rs == R_IDLE && adc_req_o) begin
          lastReqCycle = cycleCnt;
          if (chanQ.size() == 0) begin
            checkOutput("req_with_empty_queue", 32'(adc_req_o), 32'd0);
            curCh = adc_ch_o;
          end else begin
            curCh = chanQ.pop_front();
            checkOutput("adc_ch", 32'(adc_ch_o), 32'(curCh));
            if (checkSpacing) checkOutput("req_spacing", cycleCnt - prevReqCycle, spacing);
          end
          prevReqCycle = cycleCnt;
          ac = ackDelay;
          rs = R_ACK;
        end
        if (rs == R_ACK) begin
          if (ac == 0) begin
            adc_ack_i = 1'b1;
            vc = validDelay;
            rs = R_VAL;
          end else begin
            checkOutput("adc_req_held", 32'(adc_req_o), 32'd1);
            checkOutput("adc_ch_held", 32'(adc_ch_o), 32'(curCh));
            ac--;
          end
        end else if (rs == R_VAL) begin
          if (vc == validDelay) checkOutput("adc_req_drop", 32'(adc_req_o), 32'd0);
          if (vc == 0) begin
            if (int'(curCh) != muteCh) begin
              adc_valid_i = 1'b1;
              adc_data_i  = DW'($urandom);
              sbQ.push_back('{ch: curCh, data: adc_data_i});
            end
            rs = R_IDLE;
          end else begin
            vc--;
          end
        end
      end
    end
  end

  // Sample-stream monitor: stability under backpressure and scoreboard compare on each handshake.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rstn_i) begin
        holdValid = 0;
      end else begin
        if (smp_valid_o) begin
          if (holdValid) begin
            checkOutput("smp_data_stable", 32'(smp_data_o), 32'(holdData));
            checkOutput("smp_ch_stable", 32'(smp_ch_o), 32'(holdCh));
          end
          if (smp_ready_i) begin
            if (sbQ.size() == 0) begin
              checkOutput("smp_with_empty_scoreboard", 32'(smp_valid_o), 32'd0);
            end else begin
              expSmp = sbQ.pop_front();
              checkOutput("smp_ch", 32'(smp_ch_o), 32'(expSmp.ch));
              checkOutput("smp_data", 32'(smp_data_o), 32'(expSmp.data));
            end
            delivered++;
            holdValid = 0;
          end else begin
            holdValid = 1;
            holdData  = smp_data_o;
            holdCh    = smp_ch_o;
          end
        end else begin
          holdValid = 0;
        end
        if (noOverrunExpected && overrun_o) checkOutput("no_overrun", 32'(overrun_o), 32'd0);
        if (err_timeout_o) begin
`ifdef ADC_SCHED_TIMEOUT_EN
          errPulses++;
          checkOutput("timeout_latency", cycleCnt - lastReqCycle, 32'd16);
          checkOutput("timeout_req_low", 32'(adc_req_o), 32'd0);
`else
          checkOutput("err_timeout_tied", 32'(err_timeout_o), 32'd0);
`endif
        end
      end
    end
  end

  task automatic applyReset();
    rstn_i               = 1'b0;
    cfg_run_i            = 1'b0;
    cfg_ch_en_i          = '0;
    cfg_single_ch_mode_i = 1'b0;
    cfg_single_ch_sel_i  = '0;
    cfg_period_i         = '0;
    smp_ready_i          = 1'b1;
    ackDelay             = 1;
    validDelay           = 3;
    muteCh               = -1;
    chanQ.delete();
    sbQ.delete();
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_adc_req", 32'(adc_req_o), 32'd0);
    checkOutput("rst_adc_ch", 32'(adc_ch_o), 32'd0);
    checkOutput("rst_smp_valid", 32'(smp_valid_o), 32'd0);
    checkOutput("rst_smp_data", 32'(smp_data_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_overrun", 32'(overrun_o), 32'd0);
    checkOutput("rst_err_timeout", 32'(err_timeout_o), 32'd0);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("idle_busy", 32'(busy_o), 32'd0);
  endtask

  task automatic waitDelivered(input int target, input int budgetIn, input string name);
    int budget = budgetIn;
    while (delivered < target && budget > 0) begin
      @(posedge clk_i);
      #1;
      budget--;
    end
    checkOutput(name, delivered, target);
  endtask

  task automatic applyStimulus(input vec_t v);
    int target;
    applyReset();
    ackDelay = int'(v.ackDly);
    for (int k = 0; k < int'(v.nGrants); k++) chanQ.push_back(v.expCh[k]);
    cfg_ch_en_i          = v.chEn;
    cfg_single_ch_mode_i = v.single;
    cfg_single_ch_sel_i  = v.sel;
    cfg_period_i         = v.period;
    smp_ready_i          = 1'b1;
    noOverrunExpected    = 1;
    checkSpacing         = 1;
    spacing              = int'(v.period) + 1;
    target               = delivered + int'(v.nGrants);
    cfg_run_i            = 1'b1;
    prevReqCycle         = cycleCnt;
    if (v.nGrants == 0) begin
      repeat (3 * (int'(v.period) + 1)) begin
        @(posedge clk_i);
        #1;
        checkOutput("empty_busy", 32'(busy_o), 32'd0);
        checkOutput("empty_req", 32'(adc_req_o), 32'd0);
      end
    end else begin
      waitDelivered(target, (int'(v.nGrants) + 2) * (int'(v.period) + 1) + 20, "vec_deliveries");
    end
    cfg_run_i = 1'b0;
    repeat (int'(v.period) + 15) @(posedge clk_i);
    #1;
    checkOutput("vec_end_busy", 32'(busy_o), 32'd0);
    checkOutput("vec_chan_queue_empty", chanQ.size(), 32'd0);
    checkOutput("vec_sb_queue_empty", sbQ.size(), 32'd0);
    noOverrunExpected = 0;
    checkSpacing      = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int target;
    int budget;

    vecs[0] = '{chEn: 8'b1010_0101, single: 1'b0, sel: 3'd0, period: 16'd9, ackDly: 2'd1, nGrants: 4'd6,
                expCh: {3'd2, 3'd0, 3'd7, 3'd5, 3'd2, 3'd0}};
    vecs[1] = '{chEn: 8'hFF, single: 1'b1, sel: 3'd3, period: 16'd11, ackDly: 2'd0, nGrants: 4'd4,
                expCh: {3'd0, 3'd0, 3'd3, 3'd3, 3'd3, 3'd3}};
    vecs[2] = '{chEn: 8'b1111_0111, single: 1'b1, sel: 3'd3, period: 16'd9, ackDly: 2'd1, nGrants: 4'd0,
                expCh: '0};
    vecs[3] = '{chEn: 8'b0100_0010, single: 1'b0, sel: 3'd6, period: 16'd12, ackDly: 2'd2, nGrants: 4'd4,
                expCh: {3'd0, 3'd0, 3'd6, 3'd1, 3'd6, 3'd1}};
    vecs[4] = '{chEn: 8'h80, single: 1'b0, sel: 3'd0, period: 16'd10, ackDly: 2'd0, nGrants: 4'd3,
                expCh: {3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7}};
    vecs[5] = '{chEn: 8'h00, single: 1'b0, sel: 3'd0, period: 16'd9, ackDly: 2'd1, nGrants: 4'd0,
                expCh: '0};

    for (int i = 0; i < 6; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i]);
    end

    // Backpressure with a tick every cycle: every busy cycle drops a tick.
    $display("[TB] overrun and backpressure");
    applyReset();
    cfg_ch_en_i  = 8'b1010_0101;
    cfg_period_i = '0;
    smp_ready_i  = 1'b0;
    chanQ.push_back(3'd0);
    target    = delivered + 1;
    cfg_run_i = 1'b1;
    budget    = 50;
    while (!smp_valid_o && budget > 0) begin
      @(posedge clk_i);
      #1;
      budget--;
    end
    checkOutput("bp_valid_seen", 32'(smp_valid_o), 32'd1);
    repeat (20) begin
      @(posedge clk_i);
      #1;
      checkOutput("bp_overrun", 32'(overrun_o), 32'd1);
      checkOutput("bp_busy", 32'(busy_o), 32'd1);
      checkOutput("bp_valid_held", 32'(smp_valid_o), 32'd1);
      checkOutput("bp_no_req", 32'(adc_req_o), 32'd0);
    end
    smp_ready_i = 1'b1;
    cfg_run_i   = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    checkOutput("bp_one_sample", delivered, target);
    checkOutput("bp_idle", 32'(busy_o), 32'd0);
    checkOutput("bp_overrun_off", 32'(overrun_o), 32'd0);

    // Run dropped while converting: the in-flight sample must still arrive.
    $display("[TB] stop mid-conversion");
    applyReset();
    cfg_ch_en_i  = 8'b0010_0100;
    cfg_period_i = 16'd9;
    validDelay   = 6;
    chanQ.push_back(3'd2);
    target    = delivered + 1;
    cfg_run_i = 1'b1;
    budget    = 40;
    while (rs != R_VAL && budget > 0) begin
      @(posedge clk_i);
      #1;
      budget--;
    end
    checkOutput("stop_in_conv_busy", 32'(busy_o), 32'd1);
    cfg_run_i = 1'b0;
    waitDelivered(target, 40, "stop_delivered");
    repeat (30) @(posedge clk_i);
    #1;
    checkOutput("stop_idle", 32'(busy_o), 32'd0);
    checkOutput("stop_no_req", 32'(adc_req_o), 32'd0);
    checkOutput("stop_chan_queue_empty", chanQ.size(), 32'd0);

    // Reset while a sample waits in PUSH; round-robin pointer must restart.
    $display("[TB] reset mid-operation");
    applyReset();
    cfg_ch_en_i  = 8'b1010_0101;
    cfg_period_i = 16'd9;
    chanQ.push_back(3'd0);
    chanQ.push_back(3'd2);
    target    = delivered + 1;
    cfg_run_i = 1'b1;
    waitDelivered(target, 40, "rm_first_delivered");
    smp_ready_i = 1'b0;
    budget      = 40;
    while (!smp_valid_o && budget > 0) begin
      @(posedge clk_i);
      #1;
      budget--;
    end
    checkOutput("rm_in_push", 32'(smp_valid_o), 32'd1);
    checkOutput("rm_push_ch", 32'(smp_ch_o), 32'd2);
    #2;
    rstn_i = 1'b0;
    #1;
    checkOutput("rm_valid_async", 32'(smp_valid_o), 32'd0);
    checkOutput("rm_busy_async", 32'(busy_o), 32'd0);
    checkOutput("rm_ch_async", 32'(smp_ch_o), 32'd0);
    sbQ.delete();
    chanQ.delete();
    @(posedge clk_i);
    #1;
    chanQ.push_back(3'd0);
    smp_ready_i = 1'b1;
    target      = delivered + 1;
    rstn_i      = 1'b1;
    waitDelivered(target, 40, "rm_after_reset_delivered");
    cfg_run_i = 1'b0;
    repeat (20) @(posedge clk_i);
    #1;
    checkOutput("rm_chan_queue_empty", chanQ.size(), 32'd0);

`ifdef ADC_SCHED_TIMEOUT_EN
    $display("[TB] conversion timeout");
    applyReset();
    cfg_ch_en_i       = 8'b1010_0101;
    cfg_period_i      = 16'd24;
    muteCh            = 2;
    errPulses         = 0;
    noOverrunExpected = 1;
    chanQ.push_back(3'd0);
    chanQ.push_back(3'd2);
    chanQ.push_back(3'd5);
    target    = delivered + 2;
    cfg_run_i = 1'b1;
    waitDelivered(target, 200, "to_delivered");
    cfg_run_i = 1'b0;
    repeat (30) @(posedge clk_i);
    #1;
    checkOutput("to_pulses", errPulses, 32'd1);
    checkOutput("to_chan_queue_empty", chanQ.size(), 32'd0);
    checkOutput("to_idle", 32'(busy_o), 32'd0);
    noOverrunExpected = 0;
    muteCh            = -1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
